s3_writeback: RTL and testbench
===============================

# s3_writeback

Stage-3 writeback unit of the 3-stage pipelined datapath: captures the S2 result into the S3 pipeline register, drives the register-file write port (S3_WriteData/S3_WriteSelect/S3_WriteEnable), and bypasses in-flight S2/S3 results onto the S1 operands. It is the write-side counterpart of the register file's combinational read ports and keeps r0 at zero. A retired-write counter supports debug and performance checks.

## Interface
- DATA_WIDTH, 32, operand/result width
- ADDR_WIDTH, 5, register select width (32 registers)
- COUNT_WIDTH, 32, retired-write counter width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- S2_Valid  in  1  S2 holds a real instruction
- S2_WriteEnable  in  1  S2 instruction writes a register
- S2_WriteSelect  in  ADDR_WIDTH  S2 destination register
- S2_ALUOut  in  DATA_WIDTH  S2 result
- Stall  in  1  S1/S2 frozen this cycle; S3 takes a bubble
- Flush  in  1  squash S2 instruction this cycle
- S1_ReadSelect1, S1_ReadSelect2  in  ADDR_WIDTH  S1 source registers
- RF_ReadData1, RF_ReadData2  in  DATA_WIDTH  raw register-file read data
- S3_WriteData  out  DATA_WIDTH  register-file write data
- S3_WriteSelect  out  ADDR_WIDTH  register-file write select
- S3_WriteEnable  out  1  committed write this cycle
- Fwd_ReadData1, Fwd_ReadData2  out  DATA_WIDTH  bypassed S1 operands
- Retired_Count  out  COUNT_WIDTH  number of committed writes

## Operation
- Commit condition: `take = S2_Valid & S2_WriteEnable & ~Stall & ~Flush & (S2_WriteSelect != 0)`.
- Rising edge, take=1: S3_WriteData <= S2_ALUOut, S3_WriteSelect <= S2_WriteSelect, S3_WriteEnable <= 1.
- Rising edge, take=0: bubble, S3_WriteData <= 0, S3_WriteSelect <= 0, S3_WriteEnable <= 0. Any consumer that ignores the enable rewrites r0 with 0, so r0 stays 0.
- Retired_Count increments on every rising edge where S3_WriteEnable is 1, that is, on the edge that performs the write. It wraps from 2^COUNT_WIDTH−1 to 0.
- Forwarding is combinational and computed per port n independently, in priority order:
  1. S1_ReadSelectn == 0 gives 0.
  2. S2_Valid & S2_WriteEnable & ~Flush & S2_WriteSelect == sel gives S2_ALUOut (youngest wins; Stall does not block it).
  3. S3_WriteEnable & S3_WriteSelect == sel gives S3_WriteData.
  4. Otherwise RF_ReadDatan.
- Flush and Stall together behave as Flush: a bubble is captured and there is no S2 forward.

## Timing
- Reset (asynchronous, immediate): S3_WriteData=0, S3_WriteSelect=0, S3_WriteEnable=0, Retired_Count=0. Fwd outputs follow the forwarding rules with S3 invalid.
- Reset asserted mid-stream drops the S3 slot: no write and no count for it. The first capture is on the first rising edge after rst deasserts.
- Latency from S2 inputs to S3 outputs is 1 cycle. Latency from S1/S2 inputs to Fwd outputs is 0 cycles (combinational, no register).
- Back-to-back writes to the same register: S2 has priority over S3 in forwarding. The S3 write lands at the edge and the S2 value lands one edge later.
- S3 never holds: a stalled S2 instruction is re-presented and captured on the first non-stalled edge, exactly once.

## Structure
- Shared package (datapath_pkg) holds:
  - DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=5'd0
  - The S3 slot struct {valid, sel, data}, shared with the hazard logic.
- One sub-module, fwd_mux (instantiated twice), implements the 4-way priority select for one read port.
- The S3 register and the counter live in the top module.

## Test plan
- Reset then S2_Valid=1, S2_WriteEnable=1, S2_WriteSelect=5, S2_ALUOut=0xDEADBEEF: one edge later S3 shows sel=5, data=0xDEADBEEF, enable=1. One further edge later Retired_Count=1.
- S2_WriteSelect=0, S2_ALUOut=0x1234, S1_ReadSelect1=0, RF_ReadData1=0xFFFF: S3 captures a bubble (0/0/0) and Fwd_ReadData1=0.
- S3 holds r7=0x10 while S2 writes r7=0x20 and S1_ReadSelect1=S1_ReadSelect2=7: both Fwd outputs are 0x20. With S2_Valid=0 instead, both are 0x10. With neither, both equal RF_ReadData.
- Stall=1 for 3 cycles with a valid S2 write to r3, then Stall=0: S3 is a bubble for 3 cycles, then exactly one write of r3, and Retired_Count increases by exactly 1.
- Flush=1 with a valid S2 write to r4=0x55, S1_ReadSelect1=4, RF_ReadData1=0x99: Fwd_ReadData1=0x99 and no write to r4 follows.
- Preload Retired_Count near wrap (COUNT_WIDTH=4, 15 commits) and pulse rst asynchronously between edges during an S3 write:
  - after the 16th commit, the count wraps 15→0
  - the rst pulse clears all outputs immediately and no increment occurs for the dropped slot.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath widths and the S3 writeback slot seen by writeback and hazard logic.
package datapath_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] sel_t;

  typedef struct packed {
    logic  valid;
    sel_t  sel;
    data_t data;
  } s3_slot_t;

  localparam s3_slot_t S3_BUBBLE = '{valid: 1'b0, sel: ZERO_REG, data: '0};

endpackage

// File: rtl/s3_writeback_if.sv
// S2 result, S1 read-port and register-file write-port signals of the writeback stage.
interface s3_writeback_if
  import datapath_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
);

  logic                   S2_Valid;
  logic                   S2_WriteEnable;
  sel_t                   S2_WriteSelect;
  data_t                  S2_ALUOut;
  logic                   Stall;
  logic                   Flush;
  sel_t                   S1_ReadSelect1;
  sel_t                   S1_ReadSelect2;
  data_t                  RF_ReadData1;
  data_t                  RF_ReadData2;
  data_t                  S3_WriteData;
  sel_t                   S3_WriteSelect;
  logic                   S3_WriteEnable;
  data_t                  Fwd_ReadData1;
  data_t                  Fwd_ReadData2;
  logic [COUNT_WIDTH-1:0] Retired_Count;

  modport master (
    output S2_Valid, S2_WriteEnable, S2_WriteSelect, S2_ALUOut, Stall, Flush,
    output S1_ReadSelect1, S1_ReadSelect2, RF_ReadData1, RF_ReadData2,
    input  S3_WriteData, S3_WriteSelect, S3_WriteEnable,
    input  Fwd_ReadData1, Fwd_ReadData2, Retired_Count
  );

  modport slave (
    input  S2_Valid, S2_WriteEnable, S2_WriteSelect, S2_ALUOut, Stall, Flush,
    input  S1_ReadSelect1, S1_ReadSelect2, RF_ReadData1, RF_ReadData2,
    output S3_WriteData, S3_WriteSelect, S3_WriteEnable,
    output Fwd_ReadData1, Fwd_ReadData2, Retired_Count
  );

endinterface

// File: rtl/fwd_mux.sv
// One S1 read-port bypass: r0, then S2 (youngest), then S3, then register file.
module fwd_mux
  import datapath_pkg::*;
(
  input  sel_t     sel_i,
  input  logic     s2_vld_i,
  input  sel_t     s2_sel_i,
  input  data_t    s2_dat_i,
  input  s3_slot_t s3_i,
  input  data_t    rf_dat_i,
  output data_t    dat_o
);

  always_comb begin
    dat_o = rf_dat_i;
    if (sel_i == ZERO_REG) begin
      dat_o = '0;
    end else if (s2_vld_i && (s2_sel_i == sel_i)) begin
      dat_o = s2_dat_i;
    end else if (s3_i.valid && (s3_i.sel == sel_i)) begin
      dat_o = s3_i.data;
    end
  end

endmodule

// File: rtl/s3_writeback.sv
// S3 pipeline register driving the register-file write port, S1 operand bypass and
// a retired-write counter; S3 never holds, so a stall simply inserts a bubble.
module s3_writeback
  import datapath_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  s3_writeback_if.slave  wb
);

  s3_slot_t               slot_q, slot_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   take;
  logic                   s2_fwd_vld;

  // A write to r0 is turned into a bubble so the write port never disturbs r0.
  assign take = wb.S2_Valid & wb.S2_WriteEnable & ~wb.Stall & ~wb.Flush &
                (wb.S2_WriteSelect != ZERO_REG);

  assign s2_fwd_vld = wb.S2_Valid & wb.S2_WriteEnable & ~wb.Flush;

  always_comb begin
    slot_d = S3_BUBBLE;
    if (take) begin
      slot_d = '{valid: 1'b1, sel: wb.S2_WriteSelect, data: wb.S2_ALUOut};
    end
  end

  // Counts on the edge that performs the write, i.e. while S3 currently holds it.
  always_comb begin
    cnt_d = cnt_q;
    if (slot_q.valid) begin
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= S3_BUBBLE;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wb.S3_WriteData   = slot_q.data;
  assign wb.S3_WriteSelect = slot_q.sel;
  assign wb.S3_WriteEnable = slot_q.valid;
  assign wb.Retired_Count  = cnt_q;

  fwd_mux u_fwd1 (
    .sel_i    (wb.S1_ReadSelect1),
    .s2_vld_i (s2_fwd_vld),
    .s2_sel_i (wb.S2_WriteSelect),
    .s2_dat_i (wb.S2_ALUOut),
    .s3_i     (slot_q),
    .rf_dat_i (wb.RF_ReadData1),
    .dat_o    (wb.Fwd_ReadData1)
  );

  fwd_mux u_fwd2 (
    .sel_i    (wb.S1_ReadSelect2),
    .s2_vld_i (s2_fwd_vld),
    .s2_sel_i (wb.S2_WriteSelect),
    .s2_dat_i (wb.S2_ALUOut),
    .s3_i     (slot_q),
    .rf_dat_i (wb.RF_ReadData2),
    .dat_o    (wb.Fwd_ReadData2)
  );

endmodule

// File: tb/tb_s3_writeback.sv
// Directed bench for s3_writeback with a 4-bit retired counter to reach the wrap.
module tb_s3_writeback;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  s3_writeback_if #(.COUNT_WIDTH(4)) bus ();

  s3_writeback #(.COUNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic s2(input logic vld, input logic [4:0] sel, input logic [31:0] dat);
    bus.S2_Valid       = vld;
    bus.S2_WriteEnable = 1'b1;
    bus.S2_WriteSelect = sel;
    bus.S2_ALUOut      = dat;
  endtask

  task automatic chk_s3(input string tag, input logic we, input logic [4:0] sel,
                        input logic [31:0] dat);
    chk({tag, ".we"},  {31'd0, bus.S3_WriteEnable}, {31'd0, we});
    chk({tag, ".sel"}, {27'd0, bus.S3_WriteSelect}, {27'd0, sel});
    chk({tag, ".dat"}, bus.S3_WriteData, dat);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    s2(1'b0, 5'd0, 32'd0);
    bus.S2_WriteEnable = 1'b0;
    bus.Stall          = 1'b0;
    bus.Flush          = 1'b0;
    bus.S1_ReadSelect1 = 5'd0;
    bus.S1_ReadSelect2 = 5'd0;
    bus.RF_ReadData1   = 32'd0;
    bus.RF_ReadData2   = 32'd0;
    #3;
    chk_s3("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.cnt", {28'd0, bus.Retired_Count}, 32'd0);
    edge1();
    rst = 1'b0;

    // Basic capture and one-edge-later count
    s2(1'b1, 5'd5, 32'hDEADBEEF);
    edge1();
    chk_s3("cap5", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("cap5.cnt", {28'd0, bus.Retired_Count}, 32'd0);
    s2(1'b0, 5'd0, 32'd0);
    edge1();
    chk("cap5.cnt_after", {28'd0, bus.Retired_Count}, 32'd1);

    // r0 destination is a bubble, r0 read is zero
    s2(1'b1, 5'd0, 32'h1234);
    bus.S1_ReadSelect1 = 5'd0;
    bus.RF_ReadData1   = 32'hFFFF;
    #1;
    chk("r0.fwd1", bus.Fwd_ReadData1, 32'd0);
    edge1();
    chk_s3("r0.bubble", 1'b0, 5'd0, 32'd0);

    // S2 vs S3 forwarding priority on r7
    s2(1'b1, 5'd7, 32'h10);
    edge1();
    s2(1'b1, 5'd7, 32'h20);
    bus.S1_ReadSelect1 = 5'd7;
    bus.S1_ReadSelect2 = 5'd7;
    bus.RF_ReadData1   = 32'hAAAA;
    bus.RF_ReadData2   = 32'hBBBB;
    #1;
    chk("fwd_s2.p1", bus.Fwd_ReadData1, 32'h20);
    chk("fwd_s2.p2", bus.Fwd_ReadData2, 32'h20);
    bus.S2_Valid = 1'b0;
    #1;
    chk("fwd_s3.p1", bus.Fwd_ReadData1, 32'h10);
    chk("fwd_s3.p2", bus.Fwd_ReadData2, 32'h10);
    edge1();
    chk("fwd_rf.p1", bus.Fwd_ReadData1, 32'hAAAA);
    chk("fwd_rf.p2", bus.Fwd_ReadData2, 32'hBBBB);
    chk("fwd.cnt", {28'd0, bus.Retired_Count}, 32'd2);

    // Stall three cycles, then exactly one write of r3
    s2(1'b1, 5'd3, 32'h33);
    bus.Stall          = 1'b1;
    bus.S1_ReadSelect1 = 5'd3;
    #1;
    chk("stall.fwd1", bus.Fwd_ReadData1, 32'h33);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("stall.we", {31'd0, bus.S3_WriteEnable}, 32'd0);
    end
    bus.Stall = 1'b0;
    edge1();
    chk_s3("stall.rel", 1'b1, 5'd3, 32'h33);
    s2(1'b0, 5'd0, 32'd0);
    edge1();
    chk("stall.we_once", {31'd0, bus.S3_WriteEnable}, 32'd0);
    chk("stall.cnt", {28'd0, bus.Retired_Count}, 32'd3);

    // Flush blocks both S2 forward and capture
    s2(1'b1, 5'd4, 32'h55);
    bus.Flush          = 1'b1;
    bus.S1_ReadSelect1 = 5'd4;
    bus.RF_ReadData1   = 32'h99;
    #1;
    chk("flush.fwd1", bus.Fwd_ReadData1, 32'h99);
    edge1();
    chk("flush.we", {31'd0, bus.S3_WriteEnable}, 32'd0);
    bus.Flush = 1'b0;
    s2(1'b0, 5'd0, 32'd0);

    // Fresh reset, then 16 back-to-back commits for the wrap
    rst = 1'b1;
    #1;
    chk("rst2.cnt", {28'd0, bus.Retired_Count}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      s2(1'b1, 5'd1, i);
      edge1();
    end
    chk("wrap.cnt15", {28'd0, bus.Retired_Count}, 32'd15);
    chk("wrap.dat16", bus.S3_WriteData, 32'd16);
    s2(1'b1, 5'd1, 32'd17);
    edge1();
    chk("wrap.cnt0", {28'd0, bus.Retired_Count}, 32'd0);
    s2(1'b1, 5'd1, 32'd18);
    edge1();
    chk("wrap.cnt1", {28'd0, bus.Retired_Count}, 32'd1);
    chk("wrap.we18", {31'd0, bus.S3_WriteEnable}, 32'd1);

    // Asynchronous reset between edges drops the in-flight S3 write
    s2(1'b0, 5'd0, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk_s3("arst", 1'b0, 5'd0, 32'd0);
    chk("arst.cnt", {28'd0, bus.Retired_Count}, 32'd0);
    #1;
    rst = 1'b0;
    edge1();
    chk("arst.cnt_nodrop", {28'd0, bus.Retired_Count}, 32'd0);
    s2(1'b1, 5'd2, 32'hCAFE);
    edge1();
    chk_s3("post_rst", 1'b1, 5'd2, 32'hCAFE);
    s2(1'b0, 5'd0, 32'd0);
    edge1();
    chk("post_rst.cnt", {28'd0, bus.Retired_Count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
